// File: rtl/lag_pkg.sv
// Shared types and constants for the lag_measure input-lag engine.
package lag_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ARMED    = 3'd1,
        MEASURE  = 3'd2,
        DONE     = 3'd3,
        COOLDOWN = 3'd4
    } lag_state_t;

    localparam int SYNC_STAGES = 2;
    localparam int AVG_SAMPLES = 16;
    localparam int AVG_SHIFT   = 4;
    localparam int ACC_W       = 24;
    localparam int AVG_CNT_W   = 4;

endpackage

// File: rtl/lag_measure_if.sv
// Bundle of control/result signals between the tester core and lag_measure.
interface lag_measure_if
    import lag_pkg::*;
#(
    parameter int RESULT_W = 20
);
    // No back-pressure anywhere: lag_valid and avg_valid are single-cycle strobes
    // qualifying lag_us/timeout and avg_us, which hold their value between strobes.
    logic                enable;
    logic                frame_start;
    logic                sensor;
    logic                flash_request;
    logic                busy;
    logic [RESULT_W-1:0] lag_us;
    logic                lag_valid;
    logic                timeout;
    logic [RESULT_W-1:0] avg_us;
    logic                avg_valid;
    lag_state_t          state_dbg;

    modport master (
        output enable, frame_start, sensor,
        input  flash_request, busy, lag_us, lag_valid, timeout, avg_us, avg_valid, state_dbg
    );

    modport slave (
        input  enable, frame_start, sensor,
        output flash_request, busy, lag_us, lag_valid, timeout, avg_us, avg_valid, state_dbg
    );
endinterface

// File: rtl/lag_measure_sensor_filter.sv
// Photo-sensor synchroniser and debounce; level toggles after DEBOUNCE_CYCLES differing samples.
module sensor_filter
    import lag_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];

    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        rise_d  = 1'b0;
        if (synced != level_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                level_d = ~level_q;
                rise_d  = ~level_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], raw_i};
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
endmodule

// File: rtl/lag_measure.sv
// Input-lag measurement: flash request, microsecond timebase, result/timeout, optional average.
// Optional feature: define LAG_AVERAGE_EN to build the 16-sample averager.
module lag_measure
    import lag_pkg::*;
#(
    parameter int CLK_PER_US      = 27,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TIMEOUT_US      = 500000,
    parameter int RESULT_W        = 20
) (
    input  logic         clock,
    input  logic         reset,
    lag_measure_if.slave bus
);
    localparam int            PW         = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_PER_US - 1);

    lag_state_t          state_q, state_d;
    logic [PW-1:0]       presc_q, presc_d;
    logic [RESULT_W-1:0] us_q, us_d;
    logic [RESULT_W-1:0] lag_q, lag_d;
    logic                to_q, to_d;
    logic                valid_q, valid_d;
    logic                flash_q, flash_d;
    logic                level, rise;

    sensor_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_filter (
        .clock   (clock),
        .reset   (reset),
        .raw_i   (bus.sensor),
        .level_o (level),
        .rise_o  (rise)
    );

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        us_d    = us_q;
        lag_d   = lag_q;
        to_d    = to_q;
        valid_d = 1'b0;
        // Free-running timebase; only meaningful after the frame_start reload below.
        if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            if (us_q != RESULT_W'(TIMEOUT_US)) us_d = us_q + RESULT_W'(1);
        end else begin
            presc_d = presc_q + PW'(1);
        end
        case (state_q)
            IDLE: if (bus.enable && !level) state_d = ARMED;
            ARMED: begin
                if (!bus.enable) begin
                    state_d = IDLE;
                end else if (bus.frame_start) begin
                    // frame_start cycle is cycle 0, so the next cycle already holds count 1.
                    state_d = MEASURE;
                    presc_d = (CLK_PER_US > 1) ? PW'(1) : '0;
                    us_d    = (CLK_PER_US > 1) ? '0 : RESULT_W'(1);
                end
            end
            MEASURE: begin
                if (!bus.enable) begin
                    state_d = IDLE;
                end else if (rise) begin
                    state_d = DONE;
                    lag_d   = us_q;
                    to_d    = 1'b0;
                    valid_d = 1'b1;
                end else if (us_q == RESULT_W'(TIMEOUT_US)) begin
                    state_d = DONE;
                    lag_d   = '1;
                    to_d    = 1'b1;
                    valid_d = 1'b1;
                end
            end
            DONE: state_d = COOLDOWN;
            COOLDOWN: begin
                if (!bus.enable || (!level && bus.frame_start)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        flash_d = (state_d == ARMED) || (state_d == MEASURE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            presc_q <= '0;
            us_q    <= '0;
            lag_q   <= '0;
            to_q    <= 1'b0;
            valid_q <= 1'b0;
            flash_q <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            us_q    <= us_d;
            lag_q   <= lag_d;
            to_q    <= to_d;
            valid_q <= valid_d;
            flash_q <= flash_d;
        end
    end

`ifdef LAG_AVERAGE_EN
    logic [ACC_W-1:0]     acc_q, sum;
    logic [AVG_CNT_W-1:0] cnt_q;
    logic [RESULT_W-1:0]  avg_q;
    logic                 avg_valid_q;

    assign sum = acc_q + ACC_W'(lag_d);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            avg_q       <= '0;
            avg_valid_q <= 1'b0;
        end else begin
            avg_valid_q <= 1'b0;
            if (valid_d && !to_d) begin
                if (cnt_q == AVG_CNT_W'(AVG_SAMPLES - 1)) begin
                    avg_q       <= RESULT_W'(sum >> AVG_SHIFT);
                    avg_valid_q <= 1'b1;
                    acc_q       <= '0;
                    cnt_q       <= '0;
                end else begin
                    acc_q <= sum;
                    cnt_q <= cnt_q + AVG_CNT_W'(1);
                end
            end
        end
    end

    assign bus.avg_us    = avg_q;
    assign bus.avg_valid = avg_valid_q;
`else
    assign bus.avg_us    = '0;
    assign bus.avg_valid = 1'b0;
`endif

    assign bus.flash_request = flash_q;
    assign bus.busy          = (state_q != IDLE);
    assign bus.lag_us        = lag_q;
    assign bus.lag_valid     = valid_q;
    assign bus.timeout       = to_q;
    assign bus.state_dbg     = state_q;
endmodule
